// File: rtl/relu_backward.sv
// Backward ReLU: stacks per-element sign masks on the forward pass, then pops one per gradient and zeroes the gradient elements whose mask bit is clear.
// Latency: 1 cycle from gradient acceptance to grad_out_valid, 1 vector/cycle sustained when the consumer stays ready.
// Backpressure: a stalled output register blocks pops; a full stack blocks pushes; a pop wins over a push; clear blocks both.
module relu_backward #(
  parameter int VEC_SIZE   = 1,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8,
  parameter int DEPTH      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 fwd_valid,
  output logic                                 fwd_ready,
  input  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]  fwd_vec,
  input  logic                                 grad_in_valid,
  output logic                                 grad_in_ready,
  input  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]  grad_in,
  output logic                                 grad_out_valid,
  input  logic                                 grad_out_ready,
  output logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]  grad_out,
  output logic [$clog2(DEPTH+1)-1:0]           count,
  output logic                                 full,
  output logic                                 empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  // The fractional point only matters to the surrounding datapath; selection is format-agnostic.
  if (FIXED_PNT >= DATA_WIDTH) begin : g_bad_fixed_pnt
    $error("relu_backward: FIXED_PNT must be smaller than DATA_WIDTH");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("relu_backward: DEPTH must be at least 2");
  end

  logic [VEC_SIZE-1:0]                mask_q [DEPTH];
  logic [CW-1:0]                      count_q, count_d;
  logic                               gov_q, gov_d;
  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0] gout_q, gout_d;

  logic                               out_free;
  logic                               push;
  logic                               pop;
  logic [IW-1:0]                      wr_idx;
  logic [IW-1:0]                      rd_idx;
  logic [VEC_SIZE-1:0]                fwd_mask;
  logic [VEC_SIZE-1:0]                top_mask;
  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0] grad_masked;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

  // The output register can take a new vector when it is empty or being drained this cycle.
  assign out_free      = !gov_q || grad_out_ready;
  assign grad_in_ready = !clear && !empty && out_free;
  assign pop           = grad_in_valid && grad_in_ready;
  assign fwd_ready     = !clear && !full && !pop;
  assign push          = fwd_valid && fwd_ready;

  // Push writes the slot just above the top; pop reads the current top.
  assign wr_idx   = IW'(count_q);
  assign rd_idx   = IW'(count_q - CW'(1));
  assign top_mask = mask_q[rd_idx];

  // Mask is strictly-positive per element, so zero and negative pre-activations block gradient.
  always_comb begin
    fwd_mask    = '0;
    grad_masked = '0;
    for (int i = 0; i < VEC_SIZE; i++) begin
      fwd_mask[i]    = $signed(fwd_vec[i]) > 0;
      grad_masked[i] = top_mask[i] ? grad_in[i] : '0;
    end
  end

  // Next-state for occupancy and the output register; clear overrides everything.
  always_comb begin
    count_d = count_q;
    gov_d   = gov_q;
    gout_d  = gout_q;
    if (clear) begin
      count_d = '0;
      gov_d   = 1'b0;
      gout_d  = '0;
    end else if (pop) begin
      count_d = count_q - CW'(1);
      gov_d   = 1'b1;
      gout_d  = grad_masked;
    end else begin
      if (push) begin
        count_d = count_q + CW'(1);
      end
      if (gov_q && grad_out_ready) begin
        gov_d = 1'b0;
      end
    end
  end

  // Stack storage holds only mask bits and needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mask_q[wr_idx] <= fwd_mask;
    end
  end

  // Control and output registers; reset discards any in-flight gradient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      gov_q   <= 1'b0;
      gout_q  <= '0;
    end else begin
      count_q <= count_d;
      gov_q   <= gov_d;
      gout_q  <= gout_d;
    end
  end

  assign grad_out_valid = gov_q;
  assign grad_out       = gout_q;

endmodule

// File: tb/tb_relu_backward.sv
// Self-checking bench for relu_backward: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based stack model.
module tb_relu_backward;
  localparam int VS = 4;
  localparam int DW = 16;
  localparam int FP = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clear;
  logic                    fwd_valid;
  logic                    fwd_ready;
  logic [VS-1:0][DW-1:0]   fwd_vec;
  logic                    grad_in_valid;
  logic                    grad_in_ready;
  logic [VS-1:0][DW-1:0]   grad_in;
  logic                    grad_out_valid;
  logic                    grad_out_ready;
  logic [VS-1:0][DW-1:0]   grad_out;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;

  relu_backward #(.VEC_SIZE(VS), .DATA_WIDTH(DW), .FIXED_PNT(FP), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_vec(fwd_vec),
    .grad_in_valid(grad_in_valid), .grad_in_ready(grad_in_ready), .grad_in(grad_in),
    .grad_out_valid(grad_out_valid), .grad_out_ready(grad_out_ready), .grad_out(grad_out),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference model: a queue used as a stack of boolean masks, plus the pending output.
  logic [VS-1:0]        m_stack[$];
  logic                 m_vld;
  logic [VS*DW-1:0]     m_dat;
  int                   checks = 0;
  int                   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VS-1:0] mask_of(input logic [VS-1:0][DW-1:0] v);
    logic [VS-1:0] m;
    for (int i = 0; i < VS; i++) m[i] = ($signed(v[i]) > 0);
    return m;
  endfunction

  function automatic logic [VS*DW-1:0] splat(input logic [DW-1:0] x);
    logic [VS*DW-1:0] r;
    for (int i = 0; i < VS; i++) r[i*DW +: DW] = x;
    return r;
  endfunction

  task automatic model_reset();
    m_stack.delete();
    m_vld = 1'b0;
    m_dat = '0;
  endtask

  task automatic idle();
    clear = 1'b0; fwd_valid = 1'b0; grad_in_valid = 1'b0; grad_out_ready = 1'b1;
    fwd_vec = '0; grad_in = '0;
  endtask

  // Compare every output against the model, then advance both across one clock edge.
  task automatic tick();
    bit of, egir, efr;
    logic [VS-1:0] mk;
    #1;
    of   = !m_vld || grad_out_ready;
    egir = !clear && (m_stack.size() > 0) && of;
    efr  = !clear && (m_stack.size() < D) && !(grad_in_valid && egir);
    check("grad_in_ready", grad_in_ready, egir);
    check("fwd_ready", fwd_ready, efr);
    check("count", count, m_stack.size());
    check("full", full, m_stack.size() == D);
    check("empty", empty, m_stack.size() == 0);
    check("grad_out_valid", grad_out_valid, m_vld);
    check("grad_out", grad_out, m_dat);
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else if (grad_in_valid && egir) begin
      mk = m_stack.pop_back();
      for (int i = 0; i < VS; i++) m_dat[i*DW +: DW] = mk[i] ? grad_in[i] : '0;
      m_vld = 1'b1;
    end else begin
      if (m_vld && grad_out_ready) m_vld = 1'b0;
      if (fwd_valid && efr) m_stack.push_back(mask_of(fwd_vec));
    end
    @(negedge clk);
  endtask

  task automatic push_vec(input logic [VS*DW-1:0] v);
    fwd_vec = v; fwd_valid = 1'b1; tick(); fwd_valid = 1'b0;
  endtask

  task automatic send_grad(input logic [VS*DW-1:0] g);
    grad_in = g; grad_in_valid = 1'b1; tick(); grad_in_valid = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    #2;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_gov", grad_out_valid, 0);
    check("rst_gout", grad_out, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // 1: basic mask
    push_vec({16'h7FFF, 16'h0000, 16'hFF00, 16'h0100});
    send_grad(splat(16'h0200));
    #1;
    check("t1_gout", grad_out, {16'h0200, 16'h0000, 16'h0000, 16'h0200});
    check("t1_gov", grad_out_valid, 1);
    check("t1_count", count, 0);
    check("t1_empty", empty, 1);
    tick();

    // 2: LIFO order
    push_vec(splat(16'h0001));
    push_vec(splat(16'h8000));
    send_grad(splat(16'h0010));
    #1 check("t2_first", grad_out, 0);
    send_grad(splat(16'h0010));
    #1 check("t2_second", grad_out, splat(16'h0010));
    tick();

    // 3: full then empty
    fwd_vec = splat(16'h0123); fwd_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #1;
    check("t3_count", count, 4);
    check("t3_full", full, 1);
    check("t3_fwd_ready", fwd_ready, 0);
    tick();
    fwd_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_grad(splat(16'h0042));
    tick();
    grad_in_valid = 1'b1;
    tick();
    #1;
    check("t3_empty_gir", grad_in_ready, 0);
    check("t3_empty_count", count, 0);
    grad_in_valid = 1'b0;

    // 4: backpressure
    for (int i = 0; i < 3; i++) push_vec(splat(16'(i + 1)));
    grad_out_ready = 1'b0;
    send_grad(splat(16'h0333));
    grad_in = splat(16'h0444); grad_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    grad_out_ready = 1'b1;
    #1 check("t4_release_gir", grad_in_ready, 1);
    tick();
    grad_in_valid = 1'b0;

    // 5: simultaneous push/pop at count=2
    push_vec(splat(16'h0005));
    fwd_vec = splat(16'h0006); fwd_valid = 1'b1;
    grad_in = splat(16'h0077); grad_in_valid = 1'b1;
    #1;
    check("t5_fwd_ready", fwd_ready, 0);
    check("t5_gir", grad_in_ready, 1);
    tick();
    grad_in_valid = 1'b0;
    tick();
    fwd_valid = 1'b0;
    #1 check("t5_count", count, 2);

    // 6: async reset mid-operation, then synchronous clear
    push_vec(splat(16'h0009));
    push_vec(splat(16'h000A));
    send_grad(splat(16'h0100));
    idle();
    grad_out_ready = 1'b0;
    #1;
    check("t6_pre_count", count, 3);
    check("t6_pre_gov", grad_out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_gov", grad_out_valid, 0);
    check("t6_rst_gout", grad_out, 0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    grad_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_vec(splat(16'h0011));
    grad_out_ready = 1'b0;
    send_grad(splat(16'h0101));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    check("t6_clr_count", count, 0);
    check("t6_clr_gov", grad_out_valid, 0);
    grad_out_ready = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      fwd_valid      = ($urandom_range(0, 99) < 50);
      grad_in_valid  = ($urandom_range(0, 99) < 50);
      grad_out_ready = ($urandom_range(0, 99) < 70);
      clear          = ($urandom_range(0, 99) < 2);
      for (int i = 0; i < VS; i++) begin
        fwd_vec[i] = DW'($urandom);
        grad_in[i] = DW'($urandom);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
